// File: rtl/quad_count_driver.sv
// Quadrature decoder that drives a 4-bit up/down counter (enables, direction, parallel load)
// and keeps a signed count of counter wraps reported through the counter's ripple carry.
module quad_count_driver #(
   parameter int SYNC_STAGES = 2,
   parameter int WRAP_W      = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_qa,
   input  logic              i_qb,
   input  logic              i_idx,
   input  logic              i_idx_en,
   input  logic [3:0]        i_preset,
   input  logic              i_rcob,
   input  logic              i_clr_err,
   output logic              o_u_db,
   output logic              o_enpb,
   output logic              o_entb,
   output logic              o_loadb,
   output logic [3:0]        o_a,
   output logic              o_err,
   output logic [WRAP_W-1:0] o_wrap
);

   localparam int ARM_CYCLES = SYNC_STAGES + 1;
   localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
   localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(ARM_CYCLES);
   localparam logic [ARM_W-1:0]  ARM_ONE  = ARM_W'(1);
   localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

   logic [SYNC_STAGES-1:0] r_qaSync;
   logic [SYNC_STAGES-1:0] r_qbSync;
   logic [SYNC_STAGES-1:0] r_idxSync;
   logic                   r_qaPrev;
   logic                   r_qbPrev;
   logic                   r_idxPrev;
   logic [ARM_W-1:0]       r_armCnt;

   logic w_armed;
   logic w_qaCur;
   logic w_qbCur;
   logic w_idxCur;
   logic w_qaChg;
   logic w_qbChg;
   logic w_step;
   logic w_stepUp;
   logic w_illegal;
   logic w_load;
   logic w_wrapEvent;

   // Synchronizer chains plus the "previous" samples that the decoder compares against.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_qaSync  <= '0;
         r_qbSync  <= '0;
         r_idxSync <= '0;
         r_qaPrev  <= 1'b0;
         r_qbPrev  <= 1'b0;
         r_idxPrev <= 1'b0;
      end else begin
         r_qaSync  <= {r_qaSync[SYNC_STAGES-2:0], i_qa};
         r_qbSync  <= {r_qbSync[SYNC_STAGES-2:0], i_qb};
         r_idxSync <= {r_idxSync[SYNC_STAGES-2:0], i_idx};
         r_qaPrev  <= w_qaCur;
         r_qbPrev  <= w_qbCur;
         r_idxPrev <= w_idxCur;
      end
   end

   // The decoder stays quiet until the zeroed synchronizers have refilled with real input.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_armCnt <= '0;
      end else if (!w_armed) begin
         r_armCnt <= r_armCnt + ARM_ONE;
      end
   end

   assign w_armed  = (r_armCnt == ARM_DONE);
   assign w_qaCur  = r_qaSync[SYNC_STAGES-1];
   assign w_qbCur  = r_qbSync[SYNC_STAGES-1];
   assign w_idxCur = r_idxSync[SYNC_STAGES-1];

   assign w_qaChg   = w_qaCur ^ r_qaPrev;
   assign w_qbChg   = w_qbCur ^ r_qbPrev;
   assign w_step    = w_armed & (w_qaChg ^ w_qbChg);
   assign w_illegal = w_armed & w_qaChg & w_qbChg;
   // For a single-bit Gray change, old A differing from new B means a forward step.
   assign w_stepUp  = r_qaPrev ^ w_qbCur;
   assign w_load    = w_armed & i_idx_en & w_idxCur & ~r_idxPrev;

   assign w_wrapEvent = ~o_enpb & ~i_rcob;

   // Counter drive, error flag and wrap count, all registered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_u_db  <= 1'b1;
         o_enpb  <= 1'b1;
         o_entb  <= 1'b1;
         o_loadb <= 1'b1;
         o_a     <= 4'h0;
         o_err   <= 1'b0;
         o_wrap  <= '0;
      end else begin
         o_enpb  <= ~(w_step & ~w_load);
         o_entb  <= ~(w_step & ~w_load);
         o_loadb <= ~w_load;
         if (w_load) begin
            o_a <= i_preset;
         end
         if (w_step && !w_load) begin
            o_u_db <= w_stepUp;
         end
         if (w_illegal) begin
            o_err <= 1'b1;
         end else if (i_clr_err) begin
            o_err <= 1'b0;
         end
         if (w_load) begin
            o_wrap <= '0;
         end else if (w_wrapEvent) begin
            o_wrap <= o_u_db ? (o_wrap + WRAP_ONE) : (o_wrap - WRAP_ONE);
         end
      end
   end

endmodule
